// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: fetch address width,
// FSM state encoding, reset instruction word and the RVC opcode marker.
`ifndef XLEN
`define XLEN 32
`endif

package ifu_fetch_ctrl_pkg;

    localparam int unsigned XLEN = `XLEN;

    // Instruction presented on inst_o out of reset (addi x0, x0, 0)
    localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;

    // Low two bits of a full-width (non-compressed) instruction
    localparam logic [1:0] RVC_OPCODE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_ADDR_HI = 3'd3,
        ST_DATA_HI = 3'd4,
        ST_OUT     = 3'd5,
        ST_DRAIN   = 3'd6
    } fetch_state_e;

    // Word-aligned read address for a fetch PC
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_rvc_predecode.sv
// Combinational predecode of one 32-bit memory beat: picks the 16-bit half
// addressed by the PC, flags compressed instructions and requests a second
// beat when a full-width instruction straddles the word boundary.
// Build option: IFU_RVC_EN enables the compressed/straddle logic; without it
// the beat passes through unchanged and nothing is ever compressed.
module ifu_rvc_predecode
    import ifu_fetch_ctrl_pkg::*;
(
    input  logic [31:0] rdata_i,
`ifdef IFU_RVC_EN
    input  logic        sel_hi_i,
    output logic        split_c_o,
`endif
    output logic [31:0] inst_c_o,
    output logic        is_rvc_c_o
);

`ifdef IFU_RVC_EN
    logic [15:0] half_c;

    // Half select, compressed detection and straddle detection
    always_comb begin
        half_c     = sel_hi_i ? rdata_i[31:16] : rdata_i[15:0];
        is_rvc_c_o = (half_c[1:0] != RVC_OPCODE);
        split_c_o  = sel_hi_i && !is_rvc_c_o;
        inst_c_o   = is_rvc_c_o ? {16'h0000, half_c} : rdata_i;
    end
`else
    // Full-width only: the beat is the instruction
    assign inst_c_o   = rdata_i;
    assign is_rvc_c_o = 1'b0;
`endif

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: accepts a fetch request, runs the memory
// address/data handshakes, assembles the instruction (including a second beat
// for a full-width instruction at PC[1]=1) and holds it until consumed.
// Flushes abandon the fetch; a beat already requested is drained and dropped.
// Build option: IFU_RVC_EN enables compressed instructions and split fetch.
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            read_req_i,
    input  logic            stall_valid_i,
    input  logic            flush_valid_i,
    output logic [XLEN-1:0] mem_araddr_o,
    output logic            mem_arvalid_o,
    input  logic            mem_arready_i,
    input  logic [31:0]     mem_rdata_i,
    input  logic            mem_rvalid_i,
    output logic            mem_rready_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_valid_o,
    output logic            is_compressed_inst_o,
    output logic            fetch_busy_o
);

    localparam logic [XLEN-1:0] WORD_STEP = XLEN'(4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            is_comp_q, is_comp_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;

    logic [31:0]     dec_inst_c;
    logic            dec_is_rvc_c;
`ifdef IFU_RVC_EN
    logic [15:0]     hi_q, hi_d;
    logic            dec_split_c;
`endif

    ifu_rvc_predecode u_predecode (
        .rdata_i    (mem_rdata_i),
`ifdef IFU_RVC_EN
        .sel_hi_i   (pc_q[1]),
        .split_c_o  (dec_split_c),
`endif
        .inst_c_o   (dec_inst_c),
        .is_rvc_c_o (dec_is_rvc_c)
    );

    // Next-state, capture and handshake-output logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        is_comp_d = is_comp_q;
`ifdef IFU_RVC_EN
        hi_d      = hi_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (read_req_i && !stall_valid_i && !flush_valid_i) begin
                    pc_d    = pc_i;
                    addr_d  = word_align(pc_i);
                    state_d = ST_ADDR;
                end
            end

            // Address held until accepted; a flush after acceptance must drain
            ST_ADDR: begin
                if (flush_valid_i) begin
                    state_d = mem_arready_i ? ST_DRAIN : ST_IDLE;
                end else if (mem_arready_i) begin
                    state_d = ST_DATA;
                end
            end

            // A flush coinciding with the beat consumes it here, so no drain is needed
            ST_DATA: begin
                if (mem_rvalid_i) begin
                    if (flush_valid_i) begin
                        state_d = ST_IDLE;
                    end
`ifdef IFU_RVC_EN
                    else if (dec_split_c) begin
                        hi_d    = mem_rdata_i[31:16];
                        addr_d  = addr_q + WORD_STEP;
                        state_d = ST_ADDR_HI;
                    end
`endif
                    else begin
                        inst_d    = dec_inst_c;
                        is_comp_d = dec_is_rvc_c;
                        inst_pc_d = pc_q;
                        state_d   = ST_OUT;
                    end
                end else if (flush_valid_i) begin
                    state_d = ST_DRAIN;
                end
            end

`ifdef IFU_RVC_EN
            ST_ADDR_HI: begin
                if (flush_valid_i) begin
                    state_d = mem_arready_i ? ST_DRAIN : ST_IDLE;
                end else if (mem_arready_i) begin
                    state_d = ST_DATA_HI;
                end
            end

            // Upper half of the straddling instruction comes from the low half of this beat
            ST_DATA_HI: begin
                if (mem_rvalid_i) begin
                    if (flush_valid_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        inst_d    = {mem_rdata_i[15:0], hi_q};
                        is_comp_d = 1'b0;
                        inst_pc_d = pc_q;
                        state_d   = ST_OUT;
                    end
                end else if (flush_valid_i) begin
                    state_d = ST_DRAIN;
                end
            end
`endif

            ST_OUT: begin
                if (flush_valid_i) begin
                    state_d = ST_IDLE;
                end else if (!stall_valid_i) begin
                    if (read_req_i) begin
                        pc_d    = pc_i;
                        addr_d  = word_align(pc_i);
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            // Flush has no effect here; wait out the outstanding beat
            ST_DRAIN: begin
                if (mem_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        arvalid_d = (state_d == ST_ADDR) || (state_d == ST_ADDR_HI);
        rready_d  = (state_d == ST_DATA) || (state_d == ST_DATA_HI) || (state_d == ST_DRAIN);
        valid_d   = (state_d == ST_OUT);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            addr_q    <= '0;
            inst_pc_q <= '0;
            inst_q    <= NOP_INST;
            is_comp_q <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            inst_pc_q <= inst_pc_d;
            inst_q    <= inst_d;
            is_comp_q <= is_comp_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

`ifdef IFU_RVC_EN
    // Low half of a straddling instruction, held across the second beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
        end else begin
            hi_q <= hi_d;
        end
    end
`endif

    assign mem_araddr_o         = addr_q;
    assign mem_arvalid_o        = arvalid_q;
    assign mem_rready_o         = rready_q;
    assign inst_o               = inst_q;
    assign inst_pc_o            = inst_pc_q;
    assign inst_valid_o         = valid_q;
    assign is_compressed_inst_o = is_comp_q;
    assign fetch_busy_o         = busy_q;

endmodule

// File: doc/ifu_fetch_ctrl.md
IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

Interface
REQ-001 Parameter: NOP_INST, 32'h0000_0013, instruction word driven on inst_o at reset and when nothing is captured.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 pc_i  in  `XLEN  fetch address from the PC register.
REQ-005 read_req_i  in  1  fetch request, qualified by pc_i.
REQ-006 stall_valid_i  in  1  pipeline stall; holds the presented instruction.
REQ-007 flush_valid_i  in  1  discard the current fetch.
REQ-008 mem_araddr_o  out  `XLEN  word-aligned read address, bits [1:0] = 2'b00.
REQ-009 mem_arvalid_o / mem_arready_i  out / in  1  address handshake.
REQ-010 mem_rdata_i  in  32  read data.
REQ-011 mem_rvalid_i / mem_rready_o  in / out  1  data handshake.
REQ-012 inst_o  out  32  fetched instruction; compressed instructions are zero-extended.
REQ-013 inst_pc_o  out  `XLEN  PC of inst_o.
REQ-014 inst_valid_o  out  1  inst_o/inst_pc_o valid.
REQ-015 is_compressed_inst_o  out  1  inst_o is 16-bit (RVC); feeds PC increment selection.
REQ-016 fetch_busy_o  out  1  high in any state except IDLE; upstream stalls PC update.

Function
REQ-017 FSM states SHALL be IDLE, ADDR, DATA, ADDR_HI, DATA_HI, OUT, DRAIN.
REQ-018 IDLE: read_req_i=1, stall_valid_i=0, flush_valid_i=0 -> latch pc_i, go to ADDR next cycle; otherwise stay.
REQ-019 ADDR: mem_arvalid_o=1, mem_araddr_o={pc[XLEN-1:2],2'b00}, held stable until mem_arready_i=1, then DATA.
REQ-020 DATA: mem_rready_o=1; on mem_rvalid_i, select half = pc[1] ? rdata[31:16] : rdata[15:0].
REQ-021 Compressed when half[1:0] != 2'b11 -> inst_o={16'h0,half}, is_compressed=1, go to OUT.
REQ-022 Not compressed with pc[1]=0 -> inst_o=rdata, is_compressed=0, go to OUT.
REQ-023 Not compressed with pc[1]=1 -> store half, go to ADDR_HI with address = word address + 4 (wraps modulo 2^XLEN), DATA_HI then gives inst_o={rdata[15:0],stored_half}.
REQ-024 OUT: inst_valid_o=1; stall_valid_i=1 holds all outputs; stall_valid_i=0 -> IDLE next cycle, or ADDR directly if read_req_i=1 in that cycle (pc_i latched).
REQ-025 Latency with zero-wait memory SHALL be 3 cycles from request acceptance to inst_valid_o; a split fetch SHALL add 2 cycles.
REQ-026 Flush in IDLE, ADDR or OUT -> IDLE next cycle, inst_valid_o=0; a request in the flush cycle SHALL be ignored.
REQ-027 Flush in ADDR with mem_arready_i=1 in the same cycle -> DRAIN.
REQ-028 Flush in DATA, ADDR_HI-after-handshake or DATA_HI -> DRAIN; DRAIN keeps mem_rready_o=1, discards one beat, then IDLE.
REQ-029 A flush arriving while in DRAIN SHALL change nothing.
REQ-030 inst_valid_o SHALL be 0 in every state except OUT.

Reset
REQ-031 rst=0 SHALL immediately force: state IDLE, inst_o=NOP_INST, inst_pc_o=0, inst_valid_o=0, is_compressed_inst_o=0, mem_arvalid_o=0, mem_rready_o=0, fetch_busy_o=0.
REQ-032 Reset mid-transaction SHALL abandon it; no beat is drained after release.

Configuration
REQ-033 Macro IFU_RVC_EN defined: compressed detection and split fetch per REQ-020..023.
REQ-034 Macro undefined: pc[1] SHALL be ignored, inst_o=rdata, is_compressed_inst_o tied 0, ADDR_HI/DATA_HI unreachable and removed.

Structure
REQ-035 Shared package SHALL hold: FSM state encoding, NOP_INST value, RVC opcode constant 2'b11.
REQ-036 Sub-module ifu_rvc_predecode (combinational half-select + compressed flag); the FSM, the capture registers and the handshakes stay in ifu_fetch_ctrl.

Verification
REQ-037 pc=0x8000_0000, rdata=0x0000_0013, zero wait -> inst_o=0x0000_0013, is_compressed=0, inst_valid_o 3 cycles after request.
REQ-038 pc=0x8000_0002, rdata=0x4505_0000 -> inst_o=0x0000_4505, is_compressed=1, araddr=0x8000_0000.
REQ-039 pc=0x8000_0006, rdata words 0x0293_0000 then 0x0000_0010 -> araddr 0x8000_0004 then 0x8000_0008, inst_o=0x0010_0293, valid after 5 cycles.
REQ-040 Flush during DATA with rvalid delayed 4 cycles -> beat consumed in DRAIN, inst_valid_o never asserted, FSM IDLE afterwards.
REQ-041 stall_valid_i=1 for 3 cycles in OUT -> inst_o, inst_pc_o, inst_valid_o unchanged; a new request is accepted on the first unstalled cycle.
REQ-042 rst=0 while in ADDR_HI -> all outputs at reset values asynchronously; after release a new fetch completes normally.
